// File: rtl/prog_clock_div.sv
// rtl/prog_clock_div.sv - runtime-programmable clock/strobe divider with glitch-free divisor update
// Optional falling-phase tick output enabled by defining CLKDIV_FALL_TICK_EN.
module prog_clock_div #(
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 1526
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] div_i,
    input  logic             div_valid_i,
    output logic             div_ready_o,
    output logic [CNT_W-1:0] div_o,
    output logic             clk_o,
    output logic             tick_o,
    output logic             err_o
`ifdef CLKDIV_FALL_TICK_EN
    ,
    output logic             fall_tick_o
`endif
);

    if ((RESET_DIV < 2) || (RESET_DIV > (2 ** CNT_W) - 1)) begin : g_bad_reset_div
        $error("prog_clock_div: RESET_DIV out of range [2, 2^CNT_W-1]");
    end

    localparam logic [CNT_W-1:0] RST_DIV_V = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] RST_CNT_V = CNT_W'(RESET_DIV - 1);
    localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_V     = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pend;
    logic             pend_valid;

    logic             wrap;
    logic             apply_wrap;
    logic [CNT_W-1:0] div_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] half_n;
    logic             req_ok;
    logic             accept;
    logic             reject;

    // Ready is simply "nothing pending", so it is a registered flag by construction.
    assign div_ready_o = ~pend_valid;

    always_comb begin
        wrap       = (cnt == (div_o - ONE_V));
        apply_wrap = wrap & pend_valid;
        div_n      = apply_wrap ? pend : div_o;
        cnt_n      = wrap ? '0 : (cnt + ONE_V);
        half_n     = div_n >> 1;
        req_ok     = (div_i >= TWO_V);
        accept     = div_valid_i & ~pend_valid & req_ok;
        reject     = div_valid_i & ~pend_valid & ~req_ok;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt         <= RST_CNT_V;
            div_o       <= RST_DIV_V;
            pend        <= '0;
            pend_valid  <= 1'b0;
            clk_o       <= 1'b0;
            tick_o      <= 1'b0;
            err_o       <= 1'b0;
`ifdef CLKDIV_FALL_TICK_EN
            fall_tick_o <= 1'b0;
`endif
        end else begin
            err_o <= reject;
            // Accept needs pend_valid low, so it never collides with an apply below.
            if (accept) begin
                pend       <= div_i;
                pend_valid <= 1'b1;
            end
            if (en_i) begin
                cnt    <= cnt_n;
                div_o  <= div_n;
                clk_o  <= (cnt_n < half_n);
                tick_o <= (cnt_n == '0);
`ifdef CLKDIV_FALL_TICK_EN
                fall_tick_o <= (cnt_n == half_n);
`endif
                if (apply_wrap) begin
                    pend_valid <= 1'b0;
                end
            end else begin
                tick_o <= 1'b0;
`ifdef CLKDIV_FALL_TICK_EN
                fall_tick_o <= 1'b0;
`endif
                // Parking cnt at D-1 makes the next enabled cycle open a fresh period.
                if (pend_valid) begin
                    div_o      <= pend;
                    cnt        <= pend - ONE_V;
                    clk_o      <= 1'b0;
                    pend_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_clock_div.sv
// tb/tb_prog_clock_div.sv - directed self-checking bench for prog_clock_div (RESET_DIV=4)
module tb_prog_clock_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] div;
    logic        div_valid;
    logic        div_ready;
    logic [15:0] div_q;
    logic        clk_div;
    logic        tick;
    logic        err;
`ifdef CLKDIV_FALL_TICK_EN
    logic        fall_tick;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    prog_clock_div #(.CNT_W(16), .RESET_DIV(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .div_valid_i (div_valid),
        .div_ready_o (div_ready),
        .div_o       (div_q),
        .clk_o       (clk_div),
        .tick_o      (tick),
        .err_o       (err)
`ifdef CLKDIV_FALL_TICK_EN
        ,
        .fall_tick_o (fall_tick)
`endif
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic en_v);
        rst = 1'b1; en = en_v; div_valid = 1'b0; div = 16'd0;
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (clk_div !== 1'b0) begin failures++; $display("FAIL reset_clk got=%0b want=0", clk_div); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b want=0", tick); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", div_ready); end
        checks++; if (div_q !== 16'd4) begin failures++; $display("FAIL reset_div got=%0d want=4", div_q); end
    endtask

    task automatic test_basic();
        logic [7:0] ec;
        logic [7:0] et;
        ec = 8'b11001100;
        et = 8'b10001000;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++; if (clk_div !== ec[7-i]) begin failures++; $display("FAIL basic_clk[%0d] got=%0b want=%0b", i, clk_div, ec[7-i]); end
            checks++; if (tick !== et[7-i]) begin failures++; $display("FAIL basic_tick[%0d] got=%0b want=%0b", i, tick, et[7-i]); end
        end
        checks++; if (div_q !== 16'd4) begin failures++; $display("FAIL basic_div got=%0d want=4", div_q); end
    endtask

    task automatic test_load();
        logic [9:0] ec;
        logic [9:0] et;
        ec = 10'b1100011000;
        et = 10'b1000010000;
        do_reset(1'b1);
        div = 16'd5; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (tick !== 1'b1) begin failures++; $display("FAIL load_wrap_tick got=%0b want=1", tick); end
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL load_ready_low got=%0b want=0", div_ready); end
        checks++; if (div_q !== 16'd4) begin failures++; $display("FAIL load_not_at_wrap got=%0d want=4", div_q); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL load_wait_ready[%0d] got=%0b want=0", i, div_ready); end
            checks++; if (div_q !== 16'd4) begin failures++; $display("FAIL load_wait_div[%0d] got=%0d want=4", i, div_q); end
        end
        cyc();
        checks++; if (div_q !== 16'd5) begin failures++; $display("FAIL load_applied got=%0d want=5", div_q); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL load_ready_high got=%0b want=1", div_ready); end
        for (int i = 0; i < 10; i++) begin
            if (i != 0) cyc();
            checks++; if (clk_div !== ec[9-i]) begin failures++; $display("FAIL load_clk[%0d] got=%0b want=%0b", i, clk_div, ec[9-i]); end
            checks++; if (tick !== et[9-i]) begin failures++; $display("FAIL load_tick[%0d] got=%0b want=%0b", i, tick, et[9-i]); end
        end
    endtask

    task automatic test_midload();
        logic [11:0] ec;
        logic [11:0] et;
        ec = 12'b111000111000;
        et = 12'b100000100000;
        do_reset(1'b1);
        cyc(); cyc();
        div = 16'd6; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL mid_accept_ready got=%0b want=0", div_ready); end
        cyc();
        checks++; if ((clk_div !== 1'b0) || (tick !== 1'b0)) begin failures++; $display("FAIL mid_old_period clk=%0b tick=%0b want clk=0 tick=0", clk_div, tick); end
        checks++; if (div_q !== 16'd4) begin failures++; $display("FAIL mid_old_div got=%0d want=4", div_q); end
        cyc();
        checks++; if (div_q !== 16'd6) begin failures++; $display("FAIL mid_new_div got=%0d want=6", div_q); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_rise got=%0b want=1", div_ready); end
        for (int i = 0; i < 12; i++) begin
            if (i != 0) cyc();
            checks++; if (clk_div !== ec[11-i]) begin failures++; $display("FAIL mid_clk[%0d] got=%0b want=%0b", i, clk_div, ec[11-i]); end
            checks++; if (tick !== et[11-i]) begin failures++; $display("FAIL mid_tick[%0d] got=%0b want=%0b", i, tick, et[11-i]); end
        end
    endtask

    task automatic test_err();
        do_reset(1'b1);
        cyc();
        div = 16'd1; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_div1 got=%0b want=1", err); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL err_div1_ready got=%0b want=1", div_ready); end
        checks++; if (clk_div !== 1'b1) begin failures++; $display("FAIL err_div1_clk got=%0b want=1", clk_div); end
        cyc();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_div1_pulse got=%0b want=0", err); end
        checks++; if (clk_div !== 1'b0) begin failures++; $display("FAIL err_wave_clk got=%0b want=0", clk_div); end
        div = 16'd0; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_div0 got=%0b want=1", err); end
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL err_div0_ready got=%0b want=1", div_ready); end
        cyc();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_div0_pulse got=%0b want=0", err); end
        checks++; if ((tick !== 1'b1) || (div_q !== 16'd4)) begin failures++; $display("FAIL err_period tick=%0b div=%0d want tick=1 div=4", tick, div_q); end
        div = 16'd8; div_valid = 1'b1;
        cyc();
        div = 16'd0;
        cyc();
        div_valid = 1'b0;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_busy_ignored got=%0b want=0", err); end
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL err_busy_ready got=%0b want=0", div_ready); end
        cyc(); cyc();
        checks++; if ((div_q !== 16'd8) || (tick !== 1'b1)) begin failures++; $display("FAIL err_busy_apply div=%0d tick=%0b want div=8 tick=1", div_q, tick); end
    endtask

    task automatic test_enable();
        logic [7:0] ep;
        logic [7:0] ec;
        logic [7:0] et;
        ep = 8'b10001111;
        ec = 8'b11111001;
        et = 8'b10000001;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            en = ep[7-i];
            cyc();
            checks++; if (clk_div !== ec[7-i]) begin failures++; $display("FAIL en_clk[%0d] got=%0b want=%0b", i, clk_div, ec[7-i]); end
            checks++; if (tick !== et[7-i]) begin failures++; $display("FAIL en_tick[%0d] got=%0b want=%0b", i, tick, et[7-i]); end
        end
        en = 1'b1;
    endtask

    task automatic test_disabled_apply();
        do_reset(1'b0);
        div = 16'd6; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if ((div_ready !== 1'b0) || (div_q !== 16'd4)) begin failures++; $display("FAIL dis_accept ready=%0b div=%0d want ready=0 div=4", div_ready, div_q); end
        cyc();
        checks++; if (div_q !== 16'd6) begin failures++; $display("FAIL dis_apply_div got=%0d want=6", div_q); end
        checks++; if ((div_ready !== 1'b1) || (clk_div !== 1'b0) || (tick !== 1'b0)) begin failures++; $display("FAIL dis_apply_out ready=%0b clk=%0b tick=%0b want 1 0 0", div_ready, clk_div, tick); end
        en = 1'b1;
        cyc();
        checks++; if ((tick !== 1'b1) || (clk_div !== 1'b1)) begin failures++; $display("FAIL dis_fresh tick=%0b clk=%0b want 1 1", tick, clk_div); end
        cyc(); cyc();
        checks++; if (clk_div !== 1'b1) begin failures++; $display("FAIL dis_high3 got=%0b want=1", clk_div); end
        cyc();
        checks++; if (clk_div !== 1'b0) begin failures++; $display("FAIL dis_low got=%0b want=0", clk_div); end
    endtask

    task automatic test_reset_pending();
        do_reset(1'b1);
        cyc();
        div = 16'd8; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        checks++; if (div_ready !== 1'b0) begin failures++; $display("FAIL rstp_pending got=%0b want=0", div_ready); end
        rst = 1'b1;
        cyc();
        checks++; if ((div_q !== 16'd4) || (div_ready !== 1'b1)) begin failures++; $display("FAIL rstp_clear div=%0d ready=%0b want div=4 ready=1", div_q, div_ready); end
        checks++; if ((clk_div !== 1'b0) || (tick !== 1'b0)) begin failures++; $display("FAIL rstp_out clk=%0b tick=%0b want 0 0", clk_div, tick); end
        div_valid = 1'b1;
        cyc();
        checks++; if (div_ready !== 1'b1) begin failures++; $display("FAIL rstp_hs_override got=%0b want=1", div_ready); end
        rst = 1'b0; div_valid = 1'b0;
        cyc();
        checks++; if ((tick !== 1'b1) || (clk_div !== 1'b1)) begin failures++; $display("FAIL rstp_first tick=%0b clk=%0b want 1 1", tick, clk_div); end
        cyc(); cyc(); cyc(); cyc();
        checks++; if ((tick !== 1'b1) || (div_q !== 16'd4)) begin failures++; $display("FAIL rstp_lost tick=%0b div=%0d want tick=1 div=4", tick, div_q); end
    endtask

`ifdef CLKDIV_FALL_TICK_EN
    task automatic test_fall_tick();
        logic [9:0] ef;
        ef = 10'b0010000100;
        do_reset(1'b1);
        checks++; if (fall_tick !== 1'b0) begin failures++; $display("FAIL fall_reset got=%0b want=0", fall_tick); end
        div = 16'd5; div_valid = 1'b1;
        cyc();
        div_valid = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            if (i != 0) cyc();
            checks++; if (fall_tick !== ef[9-i]) begin failures++; $display("FAIL fall_tick[%0d] got=%0b want=%0b", i, fall_tick, ef[9-i]); end
        end
    endtask
`endif

    initial begin
        rst = 1'b1; en = 1'b0; div = 16'd0; div_valid = 1'b0;
        test_reset();
        test_basic();
        test_load();
        test_midload();
        test_err();
        test_enable();
        test_disabled_apply();
        test_reset_pending();
`ifdef CLKDIV_FALL_TICK_EN
        test_fall_tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
